pwr_seq_ctrl: RTL and testbench
===============================

// Module: pwr_seq_ctrl
// PURPOSE
// - Per-domain power sequencer; sits directly upstream of the power-domain state tracker.
// - Turns single-cycle on/off/retention requests into ordered control signals:
//   isolation, save/restore, switch enable and domain reset.
// - Tracks switch acknowledge with a timeout.
// - Instantiate once per domain (A, B, ...). pwr_on and iso_en drive the domain tracker.
// PARAMETERS
// - ISO_DLY  default 2   cycles iso_en is held before power-off, and before iso release on power-up
// - RST_DLY  default 4   cycles from synchronised pwr_ack=1 to dom_rst_n release
// - ACK_TO   default 16  max cycles waiting for pwr_ack to reach the required level
// - CNT_W    default 5   delay/timeout counter width; must hold max(ISO_DLY, RST_DLY, ACK_TO)
// PORTS
// - clk        in   1  clock
// - rst_n      in   1  async active-low reset
// - req_on     in   1  pulse: power up (accepted only in OFF or RET)
// - req_off    in   1  pulse: power down (accepted only in ON)
// - req_ret    in   1  qualifies req_off: 1 = retention, 0 = full off
// - pwr_ack    in   1  power-switch feedback, asynchronous; synchronised internally with 2 flops
// - pwr_on     out  1  power-switch enable
// - iso_en     out  1  isolation clamp enable
// - ret_en     out  1  retention supply/hold enable
// - save       out  1  one-cycle save pulse to retention flops
// - restore    out  1  one-cycle restore pulse
// - dom_rst_n  out  1  domain reset, active-low
// - busy       out  1  sequence in progress; requests ignored while high
// - err        out  1  sticky: ack timeout
// - pwr_state  out  2  pwr_state_t {OFF=0, ON=1, RET=2}; stable state only, holds last stable value while busy
// BEHAVIOUR
// - Reset values: pwr_on=0, iso_en=1, ret_en=0, save=0, restore=0, dom_rst_n=0, busy=0, err=0,
//   pwr_state=OFF, FSM in S_OFF, synchroniser flops=0. All outputs registered.
// - FSM states: S_OFF, S_RET, S_ON, S_PWRUP, S_RSTREL, S_RESTORE, S_ISOREL, S_ISOON, S_SAVE, S_PWRDN.
// - Request sampled at edge N; first output change visible after edge N+1.
// - Power-up path, from OFF/RET on req_on:
//   - S_PWRUP: pwr_on=1, busy=1. Wait for ack_s=1 (ack_s = synchronised ack, 2-cycle sync delay).
//   - S_RSTREL: count RST_DLY cycles, then dom_rst_n=1.
//   - S_RESTORE: entered only when coming from RET; restore=1 for exactly 1 cycle; ret_en=0.
//   - S_ISOREL: count ISO_DLY cycles, then iso_en=0.
//   - S_ON: busy=0, pwr_state=ON.
// - Power-down path, from ON on req_off:
//   - S_ISOON: iso_en=1, busy=1; hold ISO_DLY cycles.
//   - S_SAVE: entered only if req_ret was sampled 1 with req_off; save=1 for 1 cycle, ret_en=1.
//   - S_PWRDN: dom_rst_n=0 and pwr_on=0 in the same cycle. Wait for ack_s=0.
//   - Then S_RET (if retention) or S_OFF. busy=0, pwr_state updated.
// - Invalid requests are dropped silently, with no error:
//   - any request while busy;
//   - req_off in OFF/RET;
//   - req_on in ON.
// - req_on and req_off together: only the one legal in the current stable state is taken.
// - req_ret is ignored unless req_off is accepted in the same cycle.
// - Timeout: counter reloads on entry to S_PWRUP and S_PWRDN.
//   - ACK_TO cycles without the required ack level sets err=1.
//   - S_PWRUP timeout: drive pwr_on=0 and go to S_OFF (iso_en=1, dom_rst_n=0, ret_en=0; retention lost).
//   - S_PWRDN timeout: proceed to S_OFF/S_RET as normal.
//   - err clears only when a req_on is accepted.
// - Invariants, checked with SVA:
//   - iso_en=1 whenever dom_rst_n=0 or pwr_on=0;
//   - save and restore never both high;
//   - save only while pwr_on=1.
// - rst_n asserted mid-sequence: immediate return to reset values. Retention content is not preserved.
// STRUCTURE
// - pwr_seq_pkg holds:
//   - pwr_state_t (shared with the domain tracker);
//   - seq_state_t;
//   - default delay localparams.
// - Sub-module pwr_sync2: 2-flop synchroniser for pwr_ack, async reset to 0.
// - One shared down-counter for ISO/RST delays and ack timeout; only one wait is active at a time.
// TESTING (defaults ISO_DLY=2, RST_DLY=4, ACK_TO=16; ack model answers in 3 cycles)
// - Cold power-up: req_on at OFF, ack after 3 cycles.
//   - Order is pwr_on -> dom_rst_n -> iso_en low.
//   - restore never pulses. Reach ON with busy=0.
// - Full off: req_off, req_ret=0 in ON.
//   - iso_en=1 at least 2 cycles before pwr_on=0.
//   - No save. End in OFF.
// - Retention round trip: req_off with req_ret=1 -> one save pulse, ret_en=1, state RET.
//   - Then req_on -> exactly one restore pulse after dom_rst_n=1, and ret_en=0.
// - Ack timeout: pwr_ack tied 0, req_on.
//   - err=1 at 16 cycles after S_PWRUP entry; back to OFF with pwr_on=0.
//   - Next accepted req_on clears err.
// - Illegal and simultaneous requests dropped with no state change and no err:
//   - req_on while ON;
//   - req_off while busy;
//   - req_on and req_off together in ON (only req_off taken).
// - Async reset in S_SAVE: all outputs return to reset values in the same cycle.
//   - pwr_state=OFF; no further pulses.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// Shared types and default timing for the per-domain power sequencer.
package pwr_seq_pkg;

  // Stable power state, also consumed by the power-domain state tracker
  typedef enum logic [1:0] {
    PWR_OFF = 2'd0,
    PWR_ON  = 2'd1,
    PWR_RET = 2'd2
  } pwr_state_t;

  // Sequencer FSM states
  typedef enum logic [3:0] {
    S_OFF,
    S_RET,
    S_ON,
    S_PWRUP,
    S_RSTREL,
    S_RESTORE,
    S_ISOREL,
    S_ISOON,
    S_SAVE,
    S_PWRDN
  } seq_state_t;

  localparam int unsigned ISO_DLY_DEF = 2;
  localparam int unsigned RST_DLY_DEF = 4;
  localparam int unsigned ACK_TO_DEF  = 16;
  localparam int unsigned CNT_W_DEF   = 5;

endpackage

// File: rtl/pwr_sync2.sv
// Two-flop synchroniser for the asynchronous power-switch acknowledge.
module pwr_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Double-register the async input; both stages clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Per-domain power sequencer: orders isolation, save/restore, switch enable
// and domain reset around on/off/retention requests, with ack timeout.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int unsigned ISO_DLY = ISO_DLY_DEF,
  parameter int unsigned RST_DLY = RST_DLY_DEF,
  parameter int unsigned ACK_TO  = ACK_TO_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_on,
  input  logic       req_off,
  input  logic       req_ret,
  input  logic       pwr_ack,
  output logic       pwr_on,
  output logic       iso_en,
  output logic       ret_en,
  output logic       save,
  output logic       restore,
  output logic       dom_rst_n,
  output logic       busy,
  output logic       err,
  output logic [1:0] pwr_state
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ISO_C   = CNT_W'(ISO_DLY);
  localparam logic [CNT_W-1:0] RST_C   = CNT_W'(RST_DLY);
  localparam logic [CNT_W-1:0] ACK_C   = CNT_W'(ACK_TO);

  logic ack_s;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ret_mode_q, ret_mode_d;
  logic             req_on_q, req_on_d;
  logic             req_off_q, req_off_d;
  logic             req_ret_q, req_ret_d;
  logic             err_q, err_d;
  pwr_state_t       pwr_state_q, pwr_state_d;
  logic             pwr_on_q, pwr_on_d;
  logic             iso_en_q, iso_en_d;
  logic             ret_en_q, ret_en_d;
  logic             save_q, save_d;
  logic             restore_q, restore_d;
  logic             dom_rst_n_q, dom_rst_n_d;
  logic             busy_q, busy_d;
  logic             cnt_done;
  logic [CNT_W-1:0] cnt_dec;

  pwr_sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pwr_ack),
    .q     (ack_s)
  );

  // Request capture; anything arriving while busy is dropped here
  always_comb begin
    req_on_d  = req_on  && !busy_q;
    req_off_d = req_off && !busy_q;
    req_ret_d = req_ret && !busy_q;
  end

  // Next-state, shared delay/timeout counter, retention mode and sticky error
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ret_mode_d = ret_mode_q;
    err_d      = err_q;
    cnt_done   = (cnt_q <= CNT_ONE);
    cnt_dec    = cnt_q - CNT_ONE;
    case (state_q)
      S_OFF, S_RET: begin
        if (req_on_q) begin
          state_d    = S_PWRUP;
          cnt_d      = ACK_C;
          ret_mode_d = (state_q == S_RET);
          err_d      = 1'b0;
        end
      end
      S_ON: begin
        if (req_off_q) begin
          state_d    = S_ISOON;
          cnt_d      = ISO_C;
          ret_mode_d = req_ret_q;
        end
      end
      S_PWRUP: begin
        if (ack_s) begin
          state_d = S_RSTREL;
          cnt_d   = RST_C;
        end else if (cnt_done) begin
          // Switch never came up: abandon, retention content is lost
          state_d    = S_OFF;
          ret_mode_d = 1'b0;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_RSTREL: begin
        if (cnt_done) begin
          state_d = ret_mode_q ? S_RESTORE : S_ISOREL;
          cnt_d   = ISO_C;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_RESTORE: begin
        state_d    = S_ISOREL;
        cnt_d      = ISO_C;
        ret_mode_d = 1'b0;
      end
      S_ISOREL: begin
        if (cnt_done) state_d = S_ON;
        else          cnt_d   = cnt_dec;
      end
      S_ISOON: begin
        if (cnt_done) begin
          state_d = ret_mode_q ? S_SAVE : S_PWRDN;
          cnt_d   = ACK_C;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_SAVE: begin
        state_d = S_PWRDN;
        cnt_d   = ACK_C;
      end
      S_PWRDN: begin
        if (!ack_s || cnt_done) begin
          state_d = ret_mode_q ? S_RET : S_OFF;
          if (ack_s) err_d = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  // Output decode from the next state so every output flop changes together
  // with the state register; this keeps the isolation invariants glitch-free.
  always_comb begin
    pwr_on_d    = 1'b0;
    iso_en_d    = 1'b1;
    ret_en_d    = 1'b0;
    save_d      = 1'b0;
    restore_d   = 1'b0;
    dom_rst_n_d = 1'b0;
    busy_d      = 1'b1;
    pwr_state_d = pwr_state_q;
    case (state_d)
      S_OFF: begin
        busy_d      = 1'b0;
        pwr_state_d = PWR_OFF;
      end
      S_RET: begin
        ret_en_d    = 1'b1;
        busy_d      = 1'b0;
        pwr_state_d = PWR_RET;
      end
      S_ON: begin
        pwr_on_d    = 1'b1;
        iso_en_d    = 1'b0;
        dom_rst_n_d = 1'b1;
        busy_d      = 1'b0;
        pwr_state_d = PWR_ON;
      end
      S_PWRUP, S_RSTREL: begin
        pwr_on_d = 1'b1;
        ret_en_d = ret_mode_d;
      end
      S_RESTORE: begin
        pwr_on_d    = 1'b1;
        dom_rst_n_d = 1'b1;
        restore_d   = 1'b1;
      end
      S_ISOREL, S_ISOON: begin
        pwr_on_d    = 1'b1;
        dom_rst_n_d = 1'b1;
      end
      S_SAVE: begin
        pwr_on_d    = 1'b1;
        dom_rst_n_d = 1'b1;
        save_d      = 1'b1;
        ret_en_d    = 1'b1;
      end
      S_PWRDN: begin
        ret_en_d = ret_mode_d;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      ret_mode_q  <= 1'b0;
      req_on_q    <= 1'b0;
      req_off_q   <= 1'b0;
      req_ret_q   <= 1'b0;
      err_q       <= 1'b0;
      pwr_state_q <= PWR_OFF;
      pwr_on_q    <= 1'b0;
      iso_en_q    <= 1'b1;
      ret_en_q    <= 1'b0;
      save_q      <= 1'b0;
      restore_q   <= 1'b0;
      dom_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ret_mode_q  <= ret_mode_d;
      req_on_q    <= req_on_d;
      req_off_q   <= req_off_d;
      req_ret_q   <= req_ret_d;
      err_q       <= err_d;
      pwr_state_q <= pwr_state_d;
      pwr_on_q    <= pwr_on_d;
      iso_en_q    <= iso_en_d;
      ret_en_q    <= ret_en_d;
      save_q      <= save_d;
      restore_q   <= restore_d;
      dom_rst_n_q <= dom_rst_n_d;
      busy_q      <= busy_d;
    end
  end

  assign pwr_on    = pwr_on_q;
  assign iso_en    = iso_en_q;
  assign ret_en    = ret_en_q;
  assign save      = save_q;
  assign restore   = restore_q;
  assign dom_rst_n = dom_rst_n_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign pwr_state = pwr_state_q;

  a_iso_clamp: assert property (@(posedge clk) disable iff (!rst_n)
    (!dom_rst_n_q || !pwr_on_q) |-> iso_en_q);
  a_save_restore: assert property (@(posedge clk) disable iff (!rst_n)
    !(save_q && restore_q));
  a_save_pwr: assert property (@(posedge clk) disable iff (!rst_n)
    save_q |-> pwr_on_q);

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl with a 3-cycle switch-ack model.
module tb_pwr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_on, req_off, req_ret;
  logic       pwr_ack;
  logic       pwr_on, iso_en, ret_en, save, restore, dom_rst_n, busy, err;
  logic [1:0] pwr_state;

  logic [2:0] ack_pipe;
  logic       ack_en;

  int checks   = 0;
  int failures = 0;

  int t_pon_r, t_pon_f, t_rst_r, t_rst_f, t_iso_r, t_iso_f;
  int t_busy_r, t_busy_f, t_err_r, t_err_f, t_ret_r, t_ret_f;
  int t_save, t_rest, n_save, n_rest;

  logic [9:0] rst_vec;

  pwr_seq_ctrl #(
    .ISO_DLY (2),
    .RST_DLY (4),
    .ACK_TO  (16),
    .CNT_W   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_on    (req_on),
    .req_off   (req_off),
    .req_ret   (req_ret),
    .pwr_ack   (pwr_ack),
    .pwr_on    (pwr_on),
    .iso_en    (iso_en),
    .ret_en    (ret_en),
    .save      (save),
    .restore   (restore),
    .dom_rst_n (dom_rst_n),
    .busy      (busy),
    .err       (err),
    .pwr_state (pwr_state)
  );

  always #5 clk = ~clk;

  // Power switch model: ack follows pwr_on three cycles later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_pipe <= '0;
    else        ack_pipe <= {ack_pipe[1:0], pwr_on};
  end
  assign pwr_ack = ack_en & ack_pipe[2];

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one sampling edge
  task automatic pulse_req(input logic on, input logic off, input logic ret);
    req_on  = on;
    req_off = off;
    req_ret = ret;
    tick();
    req_on  = 1'b0;
    req_off = 1'b0;
    req_ret = 1'b0;
  endtask

  // Step n cycles recording the first cycle each output toggles
  task automatic observe(input int n);
    logic pp, pr, pi, pb, pe, pt;
    pp = pwr_on; pr = dom_rst_n; pi = iso_en; pb = busy; pe = err; pt = ret_en;
    t_pon_r = -1; t_pon_f = -1; t_rst_r = -1; t_rst_f = -1;
    t_iso_r = -1; t_iso_f = -1; t_busy_r = -1; t_busy_f = -1;
    t_err_r = -1; t_err_f = -1; t_ret_r = -1; t_ret_f = -1;
    t_save = -1; t_rest = -1; n_save = 0; n_rest = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if ( pwr_on    && !pp && t_pon_r  < 0) t_pon_r  = k;
      if (!pwr_on    &&  pp && t_pon_f  < 0) t_pon_f  = k;
      if ( dom_rst_n && !pr && t_rst_r  < 0) t_rst_r  = k;
      if (!dom_rst_n &&  pr && t_rst_f  < 0) t_rst_f  = k;
      if ( iso_en    && !pi && t_iso_r  < 0) t_iso_r  = k;
      if (!iso_en    &&  pi && t_iso_f  < 0) t_iso_f  = k;
      if ( busy      && !pb && t_busy_r < 0) t_busy_r = k;
      if (!busy      &&  pb && t_busy_f < 0) t_busy_f = k;
      if ( err       && !pe && t_err_r  < 0) t_err_r  = k;
      if (!err       &&  pe && t_err_f  < 0) t_err_f  = k;
      if ( ret_en    && !pt && t_ret_r  < 0) t_ret_r  = k;
      if (!ret_en    &&  pt && t_ret_f  < 0) t_ret_f  = k;
      if (save) begin
        n_save++;
        if (t_save < 0) t_save = k;
      end
      if (restore) begin
        n_rest++;
        if (t_rest < 0) t_rest = k;
      end
      pp = pwr_on; pr = dom_rst_n; pi = iso_en; pb = busy; pe = err; pt = ret_en;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst_vec = 10'b0100000000;  // pwr_on,iso,ret,save,restore,rst_n,busy,err,state[1:0]
    rst_n = 1'b0; ack_en = 1'b1;
    req_on = 1'b0; req_off = 1'b0; req_ret = 1'b0;
    tick(); tick();
    check_eq("reset_outs", {pwr_on, iso_en, ret_en, save, restore, dom_rst_n, busy, err, pwr_state}, rst_vec);
    rst_n = 1'b1;
    tick(); tick();
    check_eq("idle_outs", {pwr_on, iso_en, ret_en, save, restore, dom_rst_n, busy, err, pwr_state}, rst_vec);

    // Cold power-up
    pulse_req(1'b1, 1'b0, 1'b0);
    observe(16);
    check_eq("up_pwr_on_t", t_pon_r, 1);
    check_eq("up_busy_t", t_busy_r, 1);
    check_eq("up_rst_rel_t", t_rst_r, 11);
    check_eq("up_iso_rel_t", t_iso_f, 13);
    check_eq("up_busy_fall_t", t_busy_f, 13);
    check_eq("up_no_restore", n_rest, 0);
    check_eq("up_state", pwr_state, 1);

    // req_on while ON is dropped
    pulse_req(1'b1, 1'b0, 1'b0);
    observe(6);
    check_eq("ill_on_busy", t_busy_r, -1);
    check_eq("ill_on_state", pwr_state, 1);
    check_eq("ill_on_err", err, 0);

    // Full off
    pulse_req(1'b0, 1'b1, 1'b0);
    observe(12);
    check_eq("off_iso_t", t_iso_r, 1);
    check_eq("off_pwr_off_t", t_pon_f, 3);
    check_eq("off_rst_t", t_rst_f, 3);
    check_eq("off_no_save", n_save, 0);
    check_eq("off_busy_fall_t", t_busy_f, 9);
    check_eq("off_state", pwr_state, 0);
    check_eq("off_ret_en", ret_en, 0);

    // Back on, then retention down
    pulse_req(1'b1, 1'b0, 1'b0);
    observe(16);
    check_eq("up2_state", pwr_state, 1);
    pulse_req(1'b0, 1'b1, 1'b1);
    observe(14);
    check_eq("ret_save_n", n_save, 1);
    check_eq("ret_save_t", t_save, 3);
    check_eq("ret_en_t", t_ret_r, 3);
    check_eq("ret_pwr_off_t", t_pon_f, 4);
    check_eq("ret_busy_fall_t", t_busy_f, 10);
    check_eq("ret_state", pwr_state, 2);
    check_eq("ret_en_hold", ret_en, 1);

    // Retention wake
    pulse_req(1'b1, 1'b0, 1'b0);
    observe(18);
    check_eq("wake_rst_rel_t", t_rst_r, 11);
    check_eq("wake_restore_n", n_rest, 1);
    check_eq("wake_restore_t", t_rest, 11);
    check_eq("wake_ret_fall_t", t_ret_f, 11);
    check_eq("wake_iso_rel_t", t_iso_f, 14);
    check_eq("wake_state", pwr_state, 1);

    // Simultaneous on+off in ON: only off taken
    pulse_req(1'b1, 1'b1, 1'b0);
    observe(12);
    check_eq("sim_pwr_off_t", t_pon_f, 3);
    check_eq("sim_busy_fall_t", t_busy_f, 9);
    check_eq("sim_state", pwr_state, 0);
    check_eq("sim_err", err, 0);

    // Ack timeout with switch stuck off
    ack_en = 1'b0;
    pulse_req(1'b1, 1'b0, 1'b0);
    observe(20);
    check_eq("to_pwr_on_t", t_pon_r, 1);
    check_eq("to_err_t", t_err_r, 17);
    check_eq("to_pwr_off_t", t_pon_f, 17);
    check_eq("to_busy_fall_t", t_busy_f, 17);
    check_eq("to_no_rst_rel", t_rst_r, -1);
    check_eq("to_state", pwr_state, 0);

    // Next accepted req_on clears err; req_off while busy is dropped
    ack_en = 1'b1;
    pulse_req(1'b1, 1'b0, 1'b0);
    observe(4);
    check_eq("clr_err_t", t_err_f, 1);
    pulse_req(1'b0, 1'b1, 1'b1);
    observe(12);
    check_eq("busy_off_busy_fall_t", t_busy_f, 8);
    check_eq("busy_off_no_pwr_off", t_pon_f, -1);
    check_eq("busy_off_no_save", n_save, 0);
    check_eq("busy_off_state", pwr_state, 1);

    // Async reset while in S_SAVE
    pulse_req(1'b0, 1'b1, 1'b1);
    observe(3);
    check_eq("rst_save_seen", save, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_outs", {pwr_on, iso_en, ret_en, save, restore, dom_rst_n, busy, err, pwr_state}, rst_vec);
    tick(); tick();
    rst_n = 1'b1;
    observe(10);
    check_eq("rst_no_save", n_save, 0);
    check_eq("rst_no_restore", n_rest, 0);
    check_eq("rst_no_pwr_on", t_pon_r, -1);
    check_eq("rst_state", pwr_state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
